// File: rtl/bht_sat2_if.sv
// ---------------------------------------------------------------------------
// bht_sat2_if
//   Bundles the branch-history-table signals exchanged between the fetch
//   frontend / execute feedback path and the table itself.
//
//   master : the frontend side. It drives the lookup address, the flush and
//            debug controls, and resolved-branch updates. It receives the
//            per-lane predictions.
//   slave  : the table (bht_sat2).
//
//   Signals:
//     flush_bp_i          invalidate all entries
//     debug_mode_i        suppress learning while the core is in debug mode
//     vpc_i               fetch address of the current block
//     bht_update_valid_i  a resolved conditional branch is being reported
//     bht_update_pc_i     PC of the resolved branch
//     bht_update_taken_i  resolved outcome, 1 = taken
//     bht_pred_valid_o    per-lane: entry holds learned state
//     bht_pred_taken_o    per-lane: predicted taken
// ---------------------------------------------------------------------------
interface bht_sat2_if #(
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned VLEN            = 32
);
    logic                       flush_bp_i;
    logic                       debug_mode_i;
    logic [VLEN-1:0]            vpc_i;
    logic                       bht_update_valid_i;
    logic [VLEN-1:0]            bht_update_pc_i;
    logic                       bht_update_taken_i;
    logic [INSTR_PER_FETCH-1:0] bht_pred_valid_o;
    logic [INSTR_PER_FETCH-1:0] bht_pred_taken_o;

    modport master (
        output flush_bp_i,
        output debug_mode_i,
        output vpc_i,
        output bht_update_valid_i,
        output bht_update_pc_i,
        output bht_update_taken_i,
        input  bht_pred_valid_o,
        input  bht_pred_taken_o
    );

    modport slave (
        input  flush_bp_i,
        input  debug_mode_i,
        input  vpc_i,
        input  bht_update_valid_i,
        input  bht_update_pc_i,
        input  bht_update_taken_i,
        output bht_pred_valid_o,
        output bht_pred_taken_o
    );
endinterface

// File: rtl/bht_sat2.sv
// ---------------------------------------------------------------------------
// bht_sat2
//   Untagged branch history table with one 2-bit saturating direction counter
//   and one valid bit per 16-bit instruction slot. Each fetch block maps to one
//   row, and every lane of that row is reported combinationally. Resolved
//   branches train a single entry per cycle.
//
//   Ports:
//     clk_i   core clock; all state changes on the rising edge
//     rst_i   asynchronous, active-high reset (clears valid bits and counters)
//     bus     bht_sat2_if.slave: lookup address, flush, debug, update channel,
//             and per-lane prediction outputs
//
//   Index layout (halfword granularity):
//     pc[OFFSET +: COL_BITS]            column / lane
//     pc[OFFSET+COL_BITS +: ROW_BITS]   row
//     Higher PC bits are ignored, so aliasing between addresses is accepted.
// ---------------------------------------------------------------------------
module bht_sat2 #(
    parameter int unsigned NR_ENTRIES      = 32,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned VLEN            = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    bht_sat2_if.slave     bus
);
    localparam int unsigned OFFSET   = 1;
    localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
    localparam int unsigned IDX_BITS = COL_BITS + ROW_BITS;

    // Elaboration-time parameter sanity checks.
    if (INSTR_PER_FETCH < 2 || (INSTR_PER_FETCH & (INSTR_PER_FETCH - 1)) != 0) begin : g_chk_ipf
        $error("bht_sat2: INSTR_PER_FETCH must be a power of two >= 2");
    end
    if (NR_ENTRIES < 4 || (NR_ENTRIES & (NR_ENTRIES - 1)) != 0) begin : g_chk_entries
        $error("bht_sat2: NR_ENTRIES must be a power of two >= 4");
    end
    if ((NR_ENTRIES % INSTR_PER_FETCH) != 0 || NR_ROWS < 2) begin : g_chk_rows
        $error("bht_sat2: NR_ENTRIES must be a multiple of INSTR_PER_FETCH with at least two rows");
    end
    if (VLEN <= OFFSET + IDX_BITS) begin : g_chk_vlen
        $error("bht_sat2: VLEN too narrow for the table index");
    end

    // Entry index is {row, col}, i.e. row*INSTR_PER_FETCH + col.
    logic [NR_ENTRIES-1:0]      valid_reg;
    logic [NR_ENTRIES-1:0][1:0] cnt_reg;

    logic [IDX_BITS-1:0] upd_idx;
    logic [ROW_BITS-1:0] lookup_row;
    logic                upd_en;
    logic [1:0]          cnt_old;
    logic [1:0]          cnt_next;

    assign upd_idx    = bus.bht_update_pc_i[OFFSET+IDX_BITS-1:OFFSET];
    assign lookup_row = bus.vpc_i[OFFSET+IDX_BITS-1:OFFSET+COL_BITS];

    // Flush wins over a coincident update; debug mode freezes learning.
    assign upd_en = bus.bht_update_valid_i & ~bus.debug_mode_i & ~bus.flush_bp_i;

    // Saturating counter step. A freshly learned entry starts weakly biased
    // toward the observed outcome, so stale counter bits left behind by a
    // flush are never observed.
    always_comb begin
        cnt_old  = cnt_reg[upd_idx];
        cnt_next = cnt_old;
        if (!valid_reg[upd_idx]) begin
            cnt_next = bus.bht_update_taken_i ? 2'b10 : 2'b01;
        end else if (bus.bht_update_taken_i) begin
            if (cnt_old != 2'b11) begin
                cnt_next = cnt_old + 2'd1;
            end
        end else begin
            if (cnt_old != 2'b00) begin
                cnt_next = cnt_old - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_reg <= '0;
            cnt_reg   <= '0;
        end else if (bus.flush_bp_i) begin
            valid_reg <= '0;
        end else if (upd_en) begin
            valid_reg[upd_idx] <= 1'b1;
            cnt_reg[upd_idx]   <= cnt_next;
        end
    end

    // Lookup: every lane of the addressed row is reported. Lanes below the
    // fetch offset are not masked here; the consumer does that.
    for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_lane
        logic [IDX_BITS-1:0] lane_idx;
        assign lane_idx = {lookup_row, COL_BITS'(gi)};
        assign bus.bht_pred_valid_o[gi] = valid_reg[lane_idx];
        assign bus.bht_pred_taken_o[gi] = valid_reg[lane_idx] & cnt_reg[lane_idx][1];
    end

    // Address bits outside the index fields carry no information for the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.vpc_i[VLEN-1:OFFSET+IDX_BITS],
                              bus.vpc_i[OFFSET+COL_BITS-1:0],
                              bus.bht_update_pc_i[VLEN-1:OFFSET+IDX_BITS],
                              bus.bht_update_pc_i[OFFSET-1:0]};
endmodule

// File: tb/tb_bht_sat2.sv
// ---------------------------------------------------------------------------
// tb_bht_sat2
//   Self-checking bench for bht_sat2 (default configuration: 32 entries,
//   2 lanes, 32-bit addresses). A behavioural model holds one valid flag and
//   one integer counter per entry. It derives entry numbers from the address
//   with plain arithmetic and applies the learning rules with min/max.
// ---------------------------------------------------------------------------
module tb_bht_sat2;
    localparam int NE   = 32;
    localparam int IPF  = 2;
    localparam int VLEN = 32;

    logic clk;
    logic rst;

    bht_sat2_if #(.INSTR_PER_FETCH(IPF), .VLEN(VLEN)) bus ();

    bht_sat2 #(.NR_ENTRIES(NE), .INSTR_PER_FETCH(IPF), .VLEN(VLEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    // ---------------- reference model ----------------
    bit m_valid [NE];
    int m_cnt   [NE];

    // Entry touched by an update: halfword address modulo the table size.
    function automatic int upd_entry(logic [31:0] pc);
        return int'((pc >> 1) % NE);
    endfunction

    // Entry seen by lane i of a fetch block: row = word address modulo rows.
    function automatic int lane_entry(logic [31:0] pc, int lane);
        return int'((pc >> 2) % (NE / IPF)) * IPF + lane;
    endfunction

    function automatic logic [IPF-1:0] exp_valid(logic [31:0] pc);
        logic [IPF-1:0] v;
        for (int i = 0; i < IPF; i++) v[i] = m_valid[lane_entry(pc, i)];
        return v;
    endfunction

    function automatic logic [IPF-1:0] exp_taken(logic [31:0] pc);
        logic [IPF-1:0] t;
        for (int i = 0; i < IPF; i++)
            t[i] = m_valid[lane_entry(pc, i)] && (m_cnt[lane_entry(pc, i)] >= 2);
        return t;
    endfunction

    function automatic void model_clear_all();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 0;
        end
    endfunction

    // Applied once per rising edge with the inputs that edge samples.
    function automatic void model_edge();
        int e;
        if (rst) begin
            model_clear_all();
        end else if (bus.flush_bp_i) begin
            for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
        end else if (bus.bht_update_valid_i && !bus.debug_mode_i) begin
            e = upd_entry(bus.bht_update_pc_i);
            if (!m_valid[e]) begin
                m_valid[e] = 1'b1;
                m_cnt[e]   = bus.bht_update_taken_i ? 2 : 1;
            end else if (bus.bht_update_taken_i) begin
                m_cnt[e] = (m_cnt[e] + 1 > 3) ? 3 : m_cnt[e] + 1;
            end else begin
                m_cnt[e] = (m_cnt[e] - 1 < 0) ? 0 : m_cnt[e] - 1;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.flush_bp_i         = 1'b0;
        bus.debug_mode_i       = 1'b0;
        bus.bht_update_valid_i = 1'b0;
        bus.bht_update_pc_i    = '0;
        bus.bht_update_taken_i = 1'b0;
    endtask

    task automatic set_update(logic [31:0] pc, logic taken);
        bus.bht_update_valid_i = 1'b1;
        bus.bht_update_pc_i    = pc;
        bus.bht_update_taken_i = taken;
    endtask

    // Advance one clock: the model follows the rising edge, and control returns
    // on the falling edge so that new stimulus and checks sit mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_update(logic [31:0] pc, logic taken);
        set_update(pc, taken);
        tick();
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        bus.vpc_i = 32'h8000_0000;
        rst = 1'b1;
        model_clear_all();
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({bus.bht_pred_valid_o, bus.bht_pred_taken_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_hold: valid=%b taken=%b required 00/00",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        rst = 1'b0;
        tick();
        bus.vpc_i = 32'h8000_0000;
        #1;
        tests_run++;
        if ({bus.bht_pred_valid_o, bus.bht_pred_taken_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_after: valid=%b taken=%b required 00/00",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        $display("[TB] reset: vpc=%h valid=%b taken=%b", bus.vpc_i,
                 bus.bht_pred_valid_o, bus.bht_pred_taken_o);
    endtask

    task automatic test_learn_saturate();
        logic [31:0] pc;
        pc = 32'h8000_0004;
        bus.vpc_i = pc;
        repeat (3) do_update(pc, 1'b1);
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o[0] !== 1'b1 || bus.bht_pred_taken_o[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL learn_taken: valid0=%b taken0=%b required 1/1",
                     bus.bht_pred_valid_o[0], bus.bht_pred_taken_o[0]);
        end
        // Saturated at 3: one not-taken leaves 2, still taken.
        do_update(pc, 1'b0);
        #1;
        tests_run++;
        if (bus.bht_pred_taken_o[0] !== 1'b1 || bus.bht_pred_valid_o[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_high: valid0=%b taken0=%b required 1/1",
                     bus.bht_pred_valid_o[0], bus.bht_pred_taken_o[0]);
        end
        do_update(pc, 1'b0);
        do_update(pc, 1'b0);
        #1;
        tests_run++;
        if (bus.bht_pred_taken_o[0] !== 1'b0 || bus.bht_pred_valid_o[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL dec_to_zero: valid0=%b taken0=%b required 1/0",
                     bus.bht_pred_valid_o[0], bus.bht_pred_taken_o[0]);
        end
        // At 0: a further not-taken must not wrap to 3.
        do_update(pc, 1'b0);
        #1;
        tests_run++;
        if (bus.bht_pred_taken_o[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_low: taken0=%b required 0", bus.bht_pred_taken_o[0]);
        end
        // From 0 a single taken reaches only 1, still not taken.
        do_update(pc, 1'b1);
        #1;
        tests_run++;
        if (bus.bht_pred_taken_o[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_low_inc: taken0=%b required 0", bus.bht_pred_taken_o[0]);
        end
        tests_run++;
        if (bus.bht_pred_valid_o !== exp_valid(pc) || bus.bht_pred_taken_o !== exp_taken(pc)) begin
            tests_failed++;
            $display("FAIL learn_model: valid=%b taken=%b required %b/%b",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o, exp_valid(pc), exp_taken(pc));
        end
        $display("[TB] learn: pc=%h valid=%b taken=%b", pc,
                 bus.bht_pred_valid_o, bus.bht_pred_taken_o);
    endtask

    task automatic test_lane_mapping();
        do_update(32'h8000_0012, 1'b1);
        bus.vpc_i = 32'h8000_0010;
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b10 || bus.bht_pred_taken_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL lane_map: valid=%b taken=%b required 10/10",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        bus.vpc_i = 32'h8000_0052;
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b10 || bus.bht_pred_taken_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL alias_hit: valid=%b taken=%b required 10/10",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        $display("[TB] lanes: vpc=%h valid=%b taken=%b", bus.vpc_i,
                 bus.bht_pred_valid_o, bus.bht_pred_taken_o);
    endtask

    task automatic test_flush_priority();
        do_update(32'h8000_0008, 1'b1);
        bus.vpc_i = 32'h8000_0008;
        bus.flush_bp_i = 1'b1;
        set_update(32'h8000_000C, 1'b1);
        #1;
        // Lookups during the flush cycle still see pre-flush state.
        tests_run++;
        if (bus.bht_pred_valid_o[0] !== 1'b1 || bus.bht_pred_taken_o[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_cycle: valid0=%b taken0=%b required 1/1",
                     bus.bht_pred_valid_o[0], bus.bht_pred_taken_o[0]);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_clear: valid=%b required 00", bus.bht_pred_valid_o);
        end
        bus.vpc_i = 32'h8000_000C;
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_drops_update: valid=%b required 00", bus.bht_pred_valid_o);
        end
        bus.vpc_i = 32'h8000_0010;
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_all: valid=%b required 00", bus.bht_pred_valid_o);
        end
        do_update(32'h8000_0008, 1'b0);
        bus.vpc_i = 32'h8000_0008;
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b01 || bus.bht_pred_taken_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL relearn: valid=%b taken=%b required 01/00",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        // A weak not-taken entry flips to taken after one taken (01 -> 10).
        do_update(32'h8000_0008, 1'b1);
        #1;
        tests_run++;
        if (bus.bht_pred_taken_o !== 2'b01) begin
            tests_failed++;
            $display("FAIL relearn_inc: taken=%b required 01", bus.bht_pred_taken_o);
        end
        $display("[TB] flush: vpc=%h valid=%b taken=%b", bus.vpc_i,
                 bus.bht_pred_valid_o, bus.bht_pred_taken_o);
    endtask

    task automatic test_debug_rbw();
        bus.vpc_i = 32'h8000_0020;
        bus.debug_mode_i = 1'b1;
        set_update(32'h8000_0020, 1'b1);
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL debug_block: valid=%b required 00", bus.bht_pred_valid_o);
        end
        set_update(32'h8000_0020, 1'b1);
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b00 || bus.bht_pred_taken_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL rbw_old: valid=%b taken=%b required 00/00",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b01 || bus.bht_pred_taken_o !== 2'b01) begin
            tests_failed++;
            $display("FAIL rbw_new: valid=%b taken=%b required 01/01",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        $display("[TB] debug/rbw: vpc=%h valid=%b taken=%b", bus.vpc_i,
                 bus.bht_pred_valid_o, bus.bht_pred_taken_o);
    endtask

    task automatic test_back_to_back_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            bus.vpc_i = 32'h8000_0000 + 32'($urandom_range(0, 127)) * 2;
            if ($urandom_range(0, 9) < 7)
                set_update(32'h8000_0000 + 32'($urandom_range(0, 63)) * 2, 1'($urandom));
            bus.flush_bp_i   = ($urandom_range(0, 29) == 0);
            bus.debug_mode_i = ($urandom_range(0, 7) == 0);
            #1;
            tests_run++;
            if (bus.bht_pred_valid_o !== exp_valid(bus.vpc_i) ||
                bus.bht_pred_taken_o !== exp_taken(bus.vpc_i)) begin
                tests_failed++;
                errs++;
                $display("FAIL random[%0d]: vpc=%h valid=%b taken=%b required %b/%b",
                         n, bus.vpc_i, bus.bht_pred_valid_o, bus.bht_pred_taken_o,
                         exp_valid(bus.vpc_i), exp_taken(bus.vpc_i));
            end
            tick();
        end
        idle_inputs();
        $display("[TB] random: 400 cycles, %0d mismatching", errs);
    endtask

    task automatic test_async_reset();
        logic [31:0] pc;
        pc = 32'h8000_0030;
        bus.vpc_i = pc;
        do_update(pc, 1'b1);
        do_update(pc + 32'd2, 1'b1);
        #1;
        tests_run++;
        if (bus.bht_pred_valid_o !== 2'b11 || bus.bht_pred_taken_o !== 2'b11) begin
            tests_failed++;
            $display("FAIL pre_async: valid=%b taken=%b required 11/11",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        set_update(pc, 1'b1);
        #1;
        rst = 1'b1;
        model_clear_all();
        #1;
        tests_run++;
        if ({bus.bht_pred_valid_o, bus.bht_pred_taken_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b taken=%b required 00/00",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        #1;
        tests_run++;
        if ({bus.bht_pred_valid_o, bus.bht_pred_taken_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL post_reset: valid=%b taken=%b required 00/00",
                     bus.bht_pred_valid_o, bus.bht_pred_taken_o);
        end
        $display("[TB] async reset: vpc=%h valid=%b taken=%b", bus.vpc_i,
                 bus.bht_pred_valid_o, bus.bht_pred_taken_o);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        bus.vpc_i    = '0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_learn_saturate();
        test_lane_mapping();
        test_flush_priority();
        test_debug_rbw();
        test_back_to_back_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/bht_sat2.md
# bht_sat2

Branch history table for the 32-bit embedded core's frontend. It sits directly upstream of instruction realignment and branch prediction selection. For each fetch block it supplies one taken/not-taken hint per 16-bit instruction slot. It learns from resolved conditional branches reported back by the execute stage. The direction state is a 2-bit saturating counter per entry, plus a valid bit. The table holds 32 entries in its default configuration, which assumes compressed instructions are enabled.

## Interface
- NR_ENTRIES, 32, total counter entries; power of two, multiple of INSTR_PER_FETCH, minimum 4.
- INSTR_PER_FETCH, 2, 16-bit slots per 32-bit fetch block (one lane per slot).
- VLEN, 32, virtual address width.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_bp_i  in  1  invalidate all entries.
- debug_mode_i  in  1  core in debug mode; blocks updates.
- vpc_i  in  VLEN  fetch address of the current block.
- bht_update_valid_i  in  1  a resolved conditional branch is being reported.
- bht_update_pc_i  in  VLEN  PC of the resolved branch.
- bht_update_taken_i  in  1  resolved outcome, 1 = taken.
- bht_pred_valid_o  out  INSTR_PER_FETCH  per-lane: the entry holds learned state.
- bht_pred_taken_o  out  INSTR_PER_FETCH  per-lane: predicted taken.

## Operation
- Table organisation:
  - NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH rows, each with INSTR_PER_FETCH columns.
  - Each entry is {valid, cnt[1:0]}.
  - COL_BITS = log2(INSTR_PER_FETCH), ROW_BITS = log2(NR_ROWS), OFFSET = 1 (halfword granularity).
- Index fields:
  - row = pc[OFFSET+COL_BITS+ROW_BITS-1 : OFFSET+COL_BITS]; default pc[5:2].
  - col = pc[OFFSET+COL_BITS-1 : OFFSET]; default pc[1].
  - Higher PC bits are ignored; aliasing is accepted and there are no tags.
- Lookup:
  - Lane i reads entry (row(vpc_i), i).
  - bht_pred_valid_o[i] = valid; bht_pred_taken_o[i] = valid & cnt[1].
  - Lanes are reported regardless of vpc_i[1]. Masking lanes below the fetch offset belongs to the consumer.
- Update, when bht_update_valid_i & ~debug_mode_i & ~flush_bp_i, applied to entry (row(update_pc), col(update_pc)):
  - If the entry is invalid: valid <- 1; cnt <- taken ? 2'b10 : 2'b01.
  - If the entry is valid and taken: cnt <- min(cnt+1, 3).
  - If the entry is valid and not taken: cnt <- max(cnt-1, 0).
  - Arithmetic is 2-bit saturating: it never wraps 3->0 or 0->3.
  - Only one entry changes per cycle.
- Flush: flush_bp_i clears every valid bit in one cycle. Counters keep their values but are unobservable until the entry is re-learned, because relearning overwrites cnt.
- Priority: rst_i > flush_bp_i > update. An update coinciding with a flush is dropped.
- Debug mode: updates are suppressed; lookup stays functional.
- No stalls or backpressure: the block always accepts updates and always answers lookups.

## Timing
- Reset:
  - All valid bits <- 0 and all cnt <- 2'b00, asynchronously on rst_i assertion.
  - Outputs read all-zero while in reset and until the first update.
- Lookup is combinational from registered state: zero-cycle latency from vpc_i to the outputs.
- Update latency:
  - The entry is written at the rising edge in which the update is sampled.
  - It is visible to a lookup from the following cycle.
  - A same-cycle lookup of the entry being updated returns the old value (read-before-write).
- Flush: the edge sampling flush_bp_i clears all entries; lookups in the flush cycle still return pre-flush state.
- Reset mid-operation overrides any in-flight update or flush immediately. No pending state survives.
- Back-to-back updates to the same entry on consecutive cycles each apply to the result of the previous one.
- Implementation constraints:
  - Flip-flop storage only; no SRAM macro.
  - Width assertions on parameters at elaboration.

## Test plan
- Reset/initial:
  - Stimulus: assert rst_i, release, drive vpc_i = 0x8000_0000.
  - Required response: bht_pred_valid_o = 2'b00, bht_pred_taken_o = 2'b00.
- Learn and saturate:
  - Stimulus: update pc 0x8000_0004 taken three times.
  - Required response: lookup vpc 0x8000_0004 gives valid lane0 = 1 and taken lane0 = 1 (cnt 10->11->11).
  - Stimulus: then one not-taken update.
  - Required response: cnt = 10, still taken.
  - Stimulus: two more not-taken updates.
  - Required response: cnt = 00, taken = 0; a further not-taken leaves cnt at 00.
- Lane/column mapping:
  - Stimulus: update 0x8000_0012 taken only.
  - Required response: vpc 0x8000_0010 shows valid = 2'b10, taken = 2'b10.
  - Stimulus: lookup aliased address 0x8000_0052.
  - Required response: same entry hits.
- Flush priority:
  - Stimulus: learn 0x8000_0008, then assert flush_bp_i together with an update to 0x8000_000C.
  - Required response: next cycle both entries are invalid.
  - Stimulus: then update 0x8000_0008 not-taken.
  - Required response: cnt = 01, taken = 0.
- Debug suppression and read-before-write:
  - Stimulus: debug_mode_i = 1 with an update to 0x8000_0020.
  - Required response: the entry stays invalid.
  - Stimulus: with debug_mode_i = 0, update the entry while vpc_i points at it.
  - Required response: old value in the same cycle, new value the next cycle.
- Async reset mid-stream:
  - Stimulus: assert rst_i between clock edges during an update burst.
  - Required response: outputs drop to 0 immediately, with no edge required.
